// File: rtl/ex_div_if.sv
// Operand/result handshake between the EX stage (master) and the multi-cycle divider (slave).
interface ex_div_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    signed_div_i;
  logic [DATA_WIDTH-1:0]   opdata1_i;
  logic [DATA_WIDTH-1:0]   opdata2_i;
  logic                    start_i;
  logic                    annul_i;
  logic [2*DATA_WIDTH-1:0] result_o;
  logic                    ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/ex_div.sv
// Restoring radix-2 divider for DIV/DIVU, one quotient bit per cycle, result {rem, quo}.
// Define DIV_SIGNED_EN to honour signed_div_i; otherwise every division is unsigned.
module ex_div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst,
  ex_div_if.slave dif
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*W:0]       work_q, work_d;
  logic [W-1:0]       divisor_q, divisor_d;
  logic               ready_q, ready_d;
  logic [2*W-1:0]     result_q, result_d;

  logic               accept, start_nz;
  logic [W-1:0]       mag1, mag2, quo_mag, rem_mag, quo_fix, rem_fix;
  logic [W:0]         diff;

  assign accept   = (state_q == DivFree) && dif.start_i && !dif.annul_i;
  assign start_nz = accept && (dif.opdata2_i != '0);
  assign quo_mag  = work_q[W-1:0];
  assign rem_mag  = work_q[2*W:W+1];
  assign diff     = {1'b0, work_q[2*W-1:W]} - {1'b0, divisor_q};

`ifdef DIV_SIGNED_EN
  logic sgn_mode;
  logic quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;

  assign sgn_mode = dif.signed_div_i;
  assign mag1 = (sgn_mode && dif.opdata1_i[W-1]) ? -dif.opdata1_i : dif.opdata1_i;
  assign mag2 = (sgn_mode && dif.opdata2_i[W-1]) ? -dif.opdata2_i : dif.opdata2_i;

  always_comb begin
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    if (start_nz) begin
      quo_neg_d = sgn_mode & (dif.opdata1_i[W-1] ^ dif.opdata2_i[W-1]);
      rem_neg_d = sgn_mode & dif.opdata1_i[W-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  // Remainder follows the dividend sign; 0x80000000 / -1 wraps back to 0x80000000.
  assign quo_fix = quo_neg_q ? -quo_mag : quo_mag;
  assign rem_fix = rem_neg_q ? -rem_mag : rem_mag;
`else
  logic unused_signed;

  assign unused_signed = dif.signed_div_i;
  assign mag1    = dif.opdata1_i;
  assign mag2    = dif.opdata2_i;
  assign quo_fix = quo_mag;
  assign rem_fix = rem_mag;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    ready_d   = ready_q;
    result_d  = result_q;
    unique case (state_q)
      DivFree: begin
        if (accept) begin
          if (!start_nz) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            // Dividend is pre-shifted one place so each step compares the next partial remainder.
            work_d    = {{W{1'b0}}, mag1, 1'b0};
            divisor_d = mag2;
          end
        end
      end
      DivByZero: begin
        if (dif.annul_i) begin
          state_d = DivFree;
        end else begin
          work_d  = '0;
          state_d = DivEnd;
        end
      end
      DivOn: begin
        if (dif.annul_i) begin
          state_d = DivFree;
        end else begin
          if (diff[W]) work_d = {work_q[2*W-1:0], 1'b0};
          else         work_d = {diff[W-1:0], work_q[W-1:0], 1'b1};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = DivEnd;
        end
      end
      DivEnd: begin
        if (dif.start_i) begin
          ready_d  = 1'b1;
          result_d = {rem_fix, quo_fix};
        end else begin
          state_d  = DivFree;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign dif.ready_o  = ready_q;
  assign dif.result_o = result_q;
endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: expected {rem, quo} queued at start, compared when ready_o rises.
module tb_ex_div;
  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_div_if #(.DATA_WIDTH(W)) dif ();
  ex_div #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .dif(dif));

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] as_v, bs_v;
    longint x, y, q, r;
    if (b == 0) return 64'd0;
    if (sgn && SIGNED_EN) begin
      as_v = a;
      bs_v = b;
      x = as_v;
      y = bs_v;
    end else begin
      x = {32'd0, a};
      y = {32'd0, b};
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit scramble);
    logic [63:0] exp;
    int lat;
    int exp_lat;
    exp_lat = (b == 0) ? 2 : 33;
    @(negedge clk);
    dif.signed_div_i = sgn;
    dif.opdata1_i = a;
    dif.opdata2_i = b;
    dif.start_i = 1'b1;
    sb_q.push_back(model(sgn, a, b));
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      if (scramble) begin
        @(negedge clk);
        dif.opdata1_i = $urandom;
        dif.opdata2_i = $urandom;
        dif.signed_div_i = 1'($urandom);
      end
      @(posedge clk);
      #1;
      if (dif.ready_o) begin
        lat = c;
        break;
      end
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    exp = sb_q.pop_front();
    if (lat != 0) begin
      chk("result", dif.result_o, exp);
      @(posedge clk);
      #1;
      chk("hold_ready", 64'(dif.ready_o), 64'd1);
      chk("hold_result", dif.result_o, exp);
    end
    @(negedge clk);
    dif.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_ready", 64'(dif.ready_o), 64'd0);
    chk("drop_result", dif.result_o, 64'd0);
  endtask

  // Annul lands on the edge after 'iter' iterations; start stays high so a missed annul shows up as ready.
  task automatic annul_at(input logic [31:0] a, input logic [31:0] b, input int iter);
    logic seen;
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i = a;
    dif.opdata2_i = b;
    dif.start_i = 1'b1;
    @(posedge clk);
    repeat (iter) @(posedge clk);
    @(negedge clk);
    dif.annul_i = 1'b1;
    @(negedge clk);
    dif.annul_i = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      seen |= dif.ready_o;
    end
    @(negedge clk);
    dif.start_i = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      seen |= dif.ready_o;
    end
    chk("annul_ready", 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [31:0] ra, rb;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i = '0;
    dif.opdata2_i = '0;
    dif.start_i = 1'b0;
    dif.annul_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(dif.ready_o), 64'd0);
    chk("reset_result", dif.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div(1'b0, 32'd5, 32'd0, 1'b0);
    run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);

    annul_at(32'h1234_5678, 32'd3, 10);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    annul_at(32'd1000, 32'd9, 31);

    // Start together with annul in DivFree must not be accepted.
    @(negedge clk);
    dif.opdata1_i = 32'd5;
    dif.opdata2_i = 32'd0;
    dif.start_i = 1'b1;
    dif.annul_i = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      seen |= dif.ready_o;
    end
    @(negedge clk);
    dif.start_i = 1'b0;
    dif.annul_i = 1'b0;
    chk("start_annul_ready", 64'(seen), 64'd0);
    repeat (3) @(posedge clk);

    run_div(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
    run_div(1'b1, 32'h8765_4321, 32'h0000_0077, 1'b1);

    // Asynchronous reset in the middle of iterating.
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i = 32'd1000;
    dif.opdata2_i = 32'd3;
    dif.start_i = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    dif.start_i = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(dif.ready_o), 64'd0);
    chk("rst_mid_result", dif.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div(1'b0, 32'd1000, 32'd3, 1'b0);

    // Asynchronous reset while a result is being held.
    @(negedge clk);
    dif.opdata1_i = 32'd100;
    dif.opdata2_i = 32'd7;
    dif.start_i = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (dif.ready_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("pre_rst_ready", 64'(seen), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_end_ready", 64'(dif.ready_o), 64'd0);
    chk("rst_end_result", dif.result_o, 64'd0);
    dif.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div(1'b0, 32'd77, 32'd5, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_div(1'($urandom), ra, rb, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
